// File: rtl/datapath_pkg.sv
// Shared types and constants for the bus-datapath controller.
package datapath_pkg;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned SEL_W   = 4;

    // Opcode field values, instr[8:6]
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Bus select codes beyond R0-R7
    localparam logic [SEL_W-1:0] SEL_IMM  = 4'h8;
    localparam logic [SEL_W-1:0] SEL_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_e;

    function automatic logic [2:0] get_op(input logic [INSTR_W-1:0] ir);
        return ir[8:6];
    endfunction

    function automatic logic [2:0] get_rx(input logic [INSTR_W-1:0] ir);
        return ir[5:3];
    endfunction

    function automatic logic [2:0] get_ry(input logic [INSTR_W-1:0] ir);
        return ir[2:0];
    endfunction

    // add and sub are the only three-step instructions
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational control decode: (state, IR) -> datapath enables and selects.
module datapath_ctrl_decode
    import datapath_pkg::*;
#(
    parameter int unsigned NREG = 8
) (
    input  state_e                   state_i,
    input  logic [INSTR_W-1:0]       ir_i,
    output logic                     instr_ready_o,
    output logic [SEL_W-1:0]         mux_sel_o,
    output logic [NREG-1:0]          r_in_o,
    output logic                     a_in_o,
    output logic                     g_in_o,
    output logic                     addsub_o,
    output logic                     alu_wb_o,
    output logic                     done_o,
    output logic                     illegal_o
);

    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;

    assign op = get_op(ir_i);
    assign rx = get_rx(ir_i);
    assign ry = get_ry(ir_i);

    // Moore decode of every control output; defaults describe a quiet bus
    always_comb begin
        instr_ready_o = 1'b0;
        mux_sel_o     = SEL_NONE;
        r_in_o        = '0;
        a_in_o        = 1'b0;
        g_in_o        = 1'b0;
        addsub_o      = 1'b0;
        alu_wb_o      = 1'b0;
        done_o        = 1'b0;
        illegal_o     = 1'b0;

        unique case (state_i)
            IDLE: begin
                instr_ready_o = 1'b1;
            end
            T1: begin
                if (op[2]) begin
                    // Undefined opcode retires with no enables
                    done_o    = 1'b1;
                    illegal_o = 1'b1;
                end else begin
                    unique case (op[1:0])
                        2'b00: begin
                            mux_sel_o  = {1'b0, ry};
                            r_in_o[rx] = 1'b1;
                            done_o     = 1'b1;
                        end
                        2'b01: begin
                            mux_sel_o  = SEL_IMM;
                            r_in_o[rx] = 1'b1;
                            done_o     = 1'b1;
                        end
                        default: begin
                            mux_sel_o = {1'b0, rx};
                            a_in_o    = 1'b1;
                        end
                    endcase
                end
            end
            T2: begin
                if (is_alu_op(op)) begin
                    mux_sel_o = {1'b0, ry};
                    g_in_o    = 1'b1;
                    addsub_o  = op[0];
                end
            end
            T3: begin
                if (is_alu_op(op)) begin
                    alu_wb_o   = 1'b1;
                    r_in_o[rx] = 1'b1;
                    done_o     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle controller for the 8-register 16-bit bus datapath.
module datapath_ctrl
    import datapath_pkg::*;
#(
    parameter int unsigned NREG  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid_i,
    input  logic [INSTR_W-1:0]   instr_i,
    output logic                 instr_ready_o,
    output logic [SEL_W-1:0]     mux_sel_o,
    output logic [NREG-1:0]      r_in_o,
    output logic                 a_in_o,
    output logic                 g_in_o,
    output logic                 addsub_o,
    output logic                 alu_wb_o,
    output logic                 done_o,
    output logic                 illegal_o,
    output logic [CNT_W-1:0]     retired_o
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic                 done;

    // Next state and IR capture; instr_valid is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    ir_d    = instr_i;
                    state_d = T1;
                end
            end
            T1:      state_d = is_alu_op(get_op(ir_q)) ? T2 : IDLE;
            T2:      state_d = T3;
            T3:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Retired counter wraps silently
    always_comb begin
        retired_d = retired_q;
        if (done) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State, IR and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    datapath_ctrl_decode #(
        .NREG (NREG)
    ) u_decode (
        .state_i       (state_q),
        .ir_i          (ir_q),
        .instr_ready_o (instr_ready_o),
        .mux_sel_o     (mux_sel_o),
        .r_in_o        (r_in_o),
        .a_in_o        (a_in_o),
        .g_in_o        (g_in_o),
        .addsub_o      (addsub_o),
        .alu_wb_o      (alu_wb_o),
        .done_o        (done),
        .illegal_o     (illegal_o)
    );

    assign done_o    = done;
    assign retired_o = retired_q;

endmodule
